// File: rtl/operand_fetch.sv
// Operand fetch stage: drives register-bank read selects, forms operands A/B
// with writeback bypass and immediate select, tracks in-flight destination
// writes in a scoreboard, and hands one registered bundle to execute over a
// valid/ready handshake.
module operand_fetch #(
  parameter int NREGS  = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_rn,
  input  logic [4:0]        in_rm,
  input  logic [4:0]        in_rd,
  input  logic              in_use_rn,
  input  logic              in_use_rm,
  input  logic              in_use_imm,
  input  logic              in_writes_rd,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [3:0]        in_op,
  output logic [4:0]        rf_read_sel_1,
  output logic [4:0]        rf_read_sel_2,
  input  logic [DATA_W-1:0] rf_read_data_1,
  input  logic [DATA_W-1:0] rf_read_data_2,
  input  logic              wb_write,
  input  logic [4:0]        wb_sel,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_op_a,
  output logic [DATA_W-1:0] out_op_b,
  output logic [4:0]        out_rd,
  output logic              out_writes_rd,
  output logic [3:0]        out_op,
  output logic [15:0]       stall_cycles
);

  // Saturating increment for the stall counter; it sticks at all-ones.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [NREGS-1:0]  pending;
  logic [NREGS-1:0]  pending_nxt;
  logic              vld_p0;
  logic [DATA_W-1:0] op_a_p0;
  logic [DATA_W-1:0] op_b_p0;
  logic [4:0]        rd_p0;
  logic              writes_rd_p0;
  logic [3:0]        op_p0;
  logic [15:0]       stall_cnt;

  logic byp_a, byp_b, byp_d;
  logic raw, waw, hazard, accept;
  logic [DATA_W-1:0] op_a_nxt, op_b_nxt;

  assign rf_read_sel_1 = in_rn;
  assign rf_read_sel_2 = in_rm;

  // Hazard detection, bypass and operand selection for the incoming instruction.
  always_comb begin
    byp_a  = wb_write && (wb_sel == in_rn);
    byp_b  = wb_write && (wb_sel == in_rm);
    byp_d  = wb_write && (wb_sel == in_rd);
    // A writeback landing this cycle resolves the dependency, so it masks the stall.
    raw    = (in_use_rn && pending[in_rn] && !byp_a)
          || (in_use_rm && !in_use_imm && pending[in_rm] && !byp_b);
    waw    = in_writes_rd && pending[in_rd] && !byp_d;
    hazard = raw || waw;
    // Deliberately independent of in_valid so upstream can use it as a pure grant.
    in_ready = !hazard && (!vld_p0 || out_ready);
    accept   = in_valid && in_ready;
    op_a_nxt = byp_a ? wb_data : rf_read_data_1;
    op_b_nxt = in_use_imm ? in_imm : (byp_b ? wb_data : rf_read_data_2);
  end

  // Scoreboard update: writeback clears first, a new destination then sets (set wins).
  always_comb begin
    pending_nxt = pending;
    if (wb_write) pending_nxt[wb_sel] = 1'b0;
    if (accept && in_writes_rd) pending_nxt[in_rd] = 1'b1;
  end

  // Stage p0: registered operand bundle towards execute.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0       <= 1'b0;
      op_a_p0      <= '0;
      op_b_p0      <= '0;
      rd_p0        <= '0;
      writes_rd_p0 <= 1'b0;
      op_p0        <= '0;
    end else if (accept) begin
      vld_p0       <= 1'b1;
      op_a_p0      <= op_a_nxt;
      op_b_p0      <= op_b_nxt;
      rd_p0        <= in_rd;
      writes_rd_p0 <= in_writes_rd;
      op_p0        <= in_op;
    end else if (out_ready) begin
      vld_p0       <= 1'b0;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= pending_nxt;
  end

  // Hazard stall counter; cycles lost only to backpressure are not counted.
  always_ff @(posedge clk) begin
    if (reset)                   stall_cnt <= '0;
    else if (in_valid && hazard) stall_cnt <= sat_inc(stall_cnt);
  end

  assign out_valid     = vld_p0;
  assign out_op_a      = op_a_p0;
  assign out_op_b      = op_b_p0;
  assign out_rd        = rd_p0;
  assign out_writes_rd = writes_rd_p0;
  assign out_op        = op_p0;
  assign stall_cycles  = stall_cnt;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: a small register-bank model feeds the read
// ports, and expected values are worked out by hand for each vector.
module tb_operand_fetch;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_rn, in_rm, in_rd;
  logic              in_use_rn, in_use_rm, in_use_imm, in_writes_rd;
  logic [DATA_W-1:0] in_imm;
  logic [3:0]        in_op;
  logic [4:0]        rf_read_sel_1, rf_read_sel_2;
  logic [DATA_W-1:0] rf_read_data_1, rf_read_data_2;
  logic              wb_write;
  logic [4:0]        wb_sel;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_op_a, out_op_b;
  logic [4:0]        out_rd;
  logic              out_writes_rd;
  logic [3:0]        out_op;
  logic [15:0]       stall_cycles;

  logic [DATA_W-1:0] bank [32];
  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign rf_read_data_1 = bank[rf_read_sel_1];
  assign rf_read_data_2 = bank[rf_read_sel_2];

  operand_fetch #(.NREGS(32), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rn(in_rn), .in_rm(in_rm), .in_rd(in_rd),
    .in_use_rn(in_use_rn), .in_use_rm(in_use_rm), .in_use_imm(in_use_imm),
    .in_writes_rd(in_writes_rd), .in_imm(in_imm), .in_op(in_op),
    .rf_read_sel_1(rf_read_sel_1), .rf_read_sel_2(rf_read_sel_2),
    .rf_read_data_1(rf_read_data_1), .rf_read_data_2(rf_read_data_2),
    .wb_write(wb_write), .wb_sel(wb_sel), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op_a(out_op_a), .out_op_b(out_op_b), .out_rd(out_rd),
    .out_writes_rd(out_writes_rd), .out_op(out_op),
    .stall_cycles(stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                       input logic [4:0] rd, input logic urn, input logic urm,
                       input logic uimm, input logic wr, input logic [31:0] imm,
                       input logic [3:0] op);
    in_valid = v; in_rn = rn; in_rm = rm; in_rd = rd;
    in_use_rn = urn; in_use_rm = urm; in_use_imm = uimm; in_writes_rd = wr;
    in_imm = imm; in_op = op;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) bank[i] = 32'h100 + i;
    bank[2] = 32'd5;
    bank[3] = 32'd7;
    reset = 1'b1; out_ready = 1'b1;
    wb_write = 1'b0; wb_sel = '0; wb_data = '0;
    idle();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_op_a", out_op_a, 0);
    chk("rst_stall", stall_cycles, 0);
    chk("rst_pending", dut.pending, 0);

    // 1: r1 = r2 + r3
    drive(1, 5'd2, 5'd3, 5'd1, 1, 1, 0, 1, 32'h0, 4'h1);
    #1;
    chk("t1_in_ready", in_ready, 1);
    chk("t1_sel1", rf_read_sel_1, 2);
    chk("t1_sel2", rf_read_sel_2, 3);
    @(negedge clk);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_op_a", out_op_a, 5);
    chk("t1_op_b", out_op_b, 7);
    chk("t1_rd", out_rd, 1);
    chk("t1_op", out_op, 1);
    chk("t1_pending", dut.pending, 32'h2);

    // 2: writer of r4, then a reader of r4 stalls until writeback bypass
    drive(1, 5'd5, 5'd0, 5'd4, 1, 0, 0, 1, 32'h0, 4'h2);
    @(negedge clk);
    chk("t2_w_op_a", out_op_a, 32'h105);
    chk("t2_w_pending", dut.pending, 32'h12);
    drive(1, 5'd4, 5'd0, 5'd7, 1, 0, 0, 1, 32'h0, 4'h3);
    #1;
    chk("t2_stall_ready", in_ready, 0);
    @(negedge clk);
    chk("t2_stall1", stall_cycles, 1);
    chk("t2_bubble", out_valid, 0);
    @(negedge clk);
    chk("t2_stall2", stall_cycles, 2);
    wb_write = 1; wb_sel = 5'd4; wb_data = 32'h55;
    #1;
    chk("t2_byp_ready", in_ready, 1);
    @(negedge clk);
    wb_write = 0;
    chk("t2_valid", out_valid, 1);
    chk("t2_byp_op_a", out_op_a, 32'h55);
    chk("t2_rd", out_rd, 7);
    chk("t2_stall_hold", stall_cycles, 2);
    chk("t2_pending", dut.pending, 32'h82);

    // 3: make r9 pending, then immediate op naming rm=r9
    drive(1, 5'd0, 5'd0, 5'd9, 0, 0, 0, 1, 32'h0, 4'h4);
    @(negedge clk);
    chk("t3_w_rd", out_rd, 9);
    chk("t3_w_pending", dut.pending, 32'h282);
    drive(1, 5'd2, 5'd9, 5'd10, 1, 1, 1, 1, 32'h10, 4'h6);
    #1;
    chk("t3_ready", in_ready, 1);
    @(negedge clk);
    chk("t3_op_a", out_op_a, 5);
    chk("t3_op_b", out_op_b, 32'h10);
    chk("t3_stall", stall_cycles, 2);
    chk("t3_pending", dut.pending, 32'h682);

    // 4: backpressure holds the bundle; release loads next with no bubble
    out_ready = 0;
    drive(1, 5'd3, 5'd0, 5'd11, 1, 0, 0, 1, 32'h0, 4'h5);
    #1;
    chk("t4_bp_ready", in_ready, 0);
    repeat (2) begin
      @(negedge clk);
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_op_b", out_op_b, 32'h10);
      chk("t4_hold_rd", out_rd, 10);
      chk("t4_hold_stall", stall_cycles, 2);
    end
    out_ready = 1;
    #1;
    chk("t4_rel_ready", in_ready, 1);
    @(negedge clk);
    chk("t4_valid", out_valid, 1);
    chk("t4_op_a", out_op_a, 7);
    chk("t4_rd", out_rd, 11);
    chk("t4_op", out_op, 5);

    // 5: r6 pending; same-cycle writeback of r6 and new writer of r6
    drive(1, 5'd0, 5'd0, 5'd6, 0, 0, 0, 1, 32'h0, 4'h7);
    @(negedge clk);
    chk("t5_w_pending", dut.pending, 32'hEC2);
    drive(1, 5'd0, 5'd0, 5'd6, 0, 0, 0, 1, 32'h0, 4'h8);
    wb_write = 1; wb_sel = 5'd6; wb_data = 32'hAA;
    #1;
    chk("t5_ready", in_ready, 1);
    @(negedge clk);
    wb_write = 0;
    chk("t5_valid", out_valid, 1);
    chk("t5_op", out_op, 8);
    chk("t5_pending", dut.pending, 32'hEC2);

    // Stall counter saturation: reader of still-pending r1
    drive(1, 5'd1, 5'd0, 5'd0, 1, 0, 0, 0, 32'h0, 4'h9);
    repeat (10) @(negedge clk);
    chk("sat_mid", stall_cycles, 12);
    repeat (65530) @(negedge clk);
    chk("sat_top", stall_cycles, 16'hFFFF);

    // 6: reset with a valid bundle and pending bits
    drive(1, 5'd2, 5'd0, 5'd12, 1, 0, 0, 1, 32'h0, 4'hA);
    @(negedge clk);
    chk("t6_pre_valid", out_valid, 1);
    reset = 1;
    idle();
    @(negedge clk);
    reset = 0;
    chk("t6_valid", out_valid, 0);
    chk("t6_pending", dut.pending, 0);
    chk("t6_stall", stall_cycles, 0);
    chk("t6_op_a", out_op_a, 0);
    chk("t6_ready", in_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
